// File: rtl/seat_arbiter_pkg.sv
// Shared types and helpers for the four-seat round-robin arbiter.
package seat_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    localparam logic [1:0] SEAT_S = 2'd0;
    localparam logic [1:0] SEAT_E = 2'd1;
    localparam logic [1:0] SEAT_N = 2'd2;
    localparam logic [1:0] SEAT_W = 2'd3;

    // Two adjacent LEDs light for the granted seat.
    function automatic logic [7:0] led_pattern(input logic [1:0] seat);
        led_pattern = 8'b0000_0011 << {seat, 1'b0};
    endfunction

    function automatic logic [3:0] seat_onehot(input logic [1:0] seat);
        seat_onehot = 4'b0001 << seat;
    endfunction

endpackage

// File: rtl/seat_arbiter_if.sv
// Button inputs and display/grant outputs of the seat arbiter.
interface seat_arbiter_if;
    import seat_arb_pkg::*;

    logic       btnD;
    logic       btnR;
    logic       btnU;
    logic       btnL;
    logic [3:0] grant;
    logic       busy;
    logic [7:0] LED;

    modport master (output btnD, btnR, btnU, btnL, input grant, busy, LED);
    modport slave  (input btnD, btnR, btnU, btnL, output grant, busy, LED);

endinterface

// File: rtl/seat_arbiter_tick_gen.sv
// Free-running prescaler; tick is high for one cycle every 2^TICK_DIV+1 clocks.
module tick_gen #(
    parameter int TICK_DIV = 26
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [TICK_DIV:0] cnt_q;
    logic [TICK_DIV:0] cnt_d;

    assign tick  = cnt_q[TICK_DIV];
    assign cnt_d = tick ? '0 : cnt_q + (TICK_DIV + 1)'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seat_arbiter.sv
// Round-robin arbiter for four seats (S,E,N,W) with tick-based hold limit.
// Define ARB_EDGE_REQ_EN to latch requests on rising edges instead of using levels.
module seat_arbiter
    import seat_arb_pkg::*;
#(
    parameter int TICK_DIV   = 26,
    parameter int HOLD_TICKS = 4
) (
    input  logic          clk,
    input  logic          rst,
    seat_arbiter_if.slave bus
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_TICKS - 1);

    arb_state_e state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [7:0] led_q,   led_d;
    logic       busy_q,  busy_d;
    logic [1:0] last_q,  last_d;
    logic [3:0] hold_q,  hold_d;

    logic       tick;
    logic [3:0] raw_req;
    logic [3:0] eff_req;
    logic [1:0] pick;
    logic       found;
    logic       release_early;

    assign raw_req = {bus.btnL, bus.btnU, bus.btnR, bus.btnD};

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

`ifdef ARB_EDGE_REQ_EN
    logic [3:0] prev_q;
    logic [3:0] pend_q, pend_d;
    logic [3:0] pend_clr;

    // A seat's pending bit is consumed on the cycle it wins arbitration.
    assign pend_clr = (state_q == IDLE && found) ? seat_onehot(pick) : 4'b0000;
    assign pend_d   = (pend_q | (raw_req & ~prev_q)) & ~pend_clr;
    assign eff_req  = pend_q;
    assign release_early = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 4'b0000;
            pend_q <= 4'b0000;
        end else begin
            prev_q <= raw_req;
            pend_q <= pend_d;
        end
    end
`else
    assign eff_req       = raw_req;
    assign release_early = ~|(eff_req & grant_q);
`endif

    // Search starts at the seat after the previous grantee.
    always_comb begin
        pick  = SEAT_S;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!found && eff_req[last_q + 2'(i)]) begin
                found = 1'b1;
                pick  = last_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        led_d   = led_q;
        busy_d  = busy_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (found) begin
                    state_d = GRANT;
                    grant_d = seat_onehot(pick);
                    led_d   = led_pattern(pick);
                    busy_d  = 1'b1;
                    last_d  = pick;
                    hold_d  = 4'd0;
                end
            end
            GRANT: begin
                if (release_early || (tick && hold_q == HOLD_LAST)) begin
                    state_d = GAP;
                    grant_d = 4'b0000;
                    led_d   = 8'h00;
                end else if (tick) begin
                    hold_d = hold_q + 4'd1;
                end
            end
            GAP: begin
                grant_d = 4'b0000;
                led_d   = 8'h00;
                busy_d  = 1'b1;
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                led_d   = 8'h00;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            led_q   <= 8'h00;
            busy_q  <= 1'b0;
            last_q  <= SEAT_W;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.LED   = led_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_seat_arbiter.sv
// Directed bench for seat_arbiter with TICK_DIV=2 (tick every 5 clocks), HOLD_TICKS=2.
module tb_seat_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   n;
    int   cnt;

    seat_arbiter_if bus();

    seat_arbiter #(.TICK_DIV(2), .HOLD_TICKS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench on a negedge with rst just released; next posedge is edge 1.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic btns(input logic d, input logic r, input logic u, input logic l);
        bus.btnD = d;
        bus.btnR = r;
        bus.btnU = u;
        bus.btnL = l;
    endtask

    logic [3:0] exp_g   [5];
    logic [7:0] exp_led [5];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        btns(0, 0, 0, 0);
        exp_g   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_led = '{8'h03, 8'h0C, 8'h30, 8'hC0, 8'h03};

`ifndef ARB_EDGE_REQ_EN
        // btnU held through reset: grant after edge 1, GAP after edge 10, regrant after edge 16
        btns(0, 0, 1, 0);
        do_reset();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_led",   32'(bus.LED),   32'h00);
        chk("rst_busy",  32'(bus.busy),  32'h0);
        step();
        chk("u_grant", 32'(bus.grant), 32'h4);
        chk("u_led",   32'(bus.LED),   32'h30);
        chk("u_busy",  32'(bus.busy),  32'h1);
        n = 0;
        while (bus.grant == 4'b0100 && n < 30) begin step(); n++; end
        chk("u_hold_len", n, 9);
        chk("u_gap_grant", 32'(bus.grant), 32'h0);
        chk("u_gap_led",   32'(bus.LED),   32'h00);
        chk("u_gap_busy",  32'(bus.busy),  32'h1);
        n = 0;
        while (bus.grant == 4'b0000 && n < 30) begin step(); n++; end
        chk("u_gap_len", n, 6);
        chk("u_regrant", 32'(bus.grant), 32'h4);

        // all four held: S,E,N,W,S with a dark GAP between each
        btns(1, 1, 1, 1);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (bus.grant == 4'b0000 && n < 30) begin step(); n++; end
            chk("rr_grant", 32'(bus.grant), 32'(exp_g[k]));
            chk("rr_led",   32'(bus.LED),   32'(exp_led[k]));
            n = 0;
            while (bus.grant != 4'b0000 && n < 30) begin step(); n++; end
            chk("rr_gap_led",  32'(bus.LED),  32'h00);
            chk("rr_gap_busy", 32'(bus.busy), 32'h1);
        end

        // btnR pulsed for 3 cycles: 3 grant cycles, early GAP, IDLE at the tick on edge 10
        btns(0, 0, 0, 0);
        do_reset();
        step();
        step();
        chk("idle_grant", 32'(bus.grant), 32'h0);
        chk("idle_busy",  32'(bus.busy),  32'h0);
        bus.btnR = 1'b1;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.grant == 4'b0010) cnt++;
        end
        bus.btnR = 1'b0;
        step();
        chk("pulse_len",   cnt, 3);
        chk("pulse_gap_g", 32'(bus.grant), 32'h0);
        chk("pulse_gap_b", 32'(bus.busy),  32'h1);
        chk("pulse_gap_l", 32'(bus.LED),   32'h00);
        n = 0;
        while (bus.busy && n < 10) begin step(); n++; end
        chk("pulse_to_idle", n, 4);
        chk("pulse_idle_g", 32'(bus.grant), 32'h0);
`else
        // one-cycle btnL pulse: pending at edge 3, grant at edge 4, GAP at edge 10
        btns(0, 0, 0, 0);
        do_reset();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_busy",  32'(bus.busy),  32'h0);
        step();
        step();
        bus.btnL = 1'b1;
        step();
        bus.btnL = 1'b0;
        step();
        chk("w_grant", 32'(bus.grant), 32'h8);
        chk("w_led",   32'(bus.LED),   32'hC0);
        chk("w_pend",  32'(dut.pend_q[3]), 32'h0);
        n = 0;
        while (bus.grant == 4'b1000 && n < 30) begin step(); n++; end
        chk("w_hold_len", n, 6);
        chk("w_gap_busy", 32'(bus.busy), 32'h1);
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (bus.grant != 4'b0000) cnt++;
        end
        chk("w_no_regrant", cnt, 0);
`endif

        // reset mid-grant drops outputs at once; S then wins over E
        btns(0, 1, 0, 0);
        do_reset();
        step();
        chk("r_grant", 32'(bus.grant), 32'h2);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_grant", 32'(bus.grant), 32'h0);
        chk("rst_mid_led",   32'(bus.LED),   32'h00);
        chk("rst_mid_busy",  32'(bus.busy),  32'h0);
        bus.btnD = 1'b1;
        step();
        rst = 1'b1;
        step();
        chk("post_rst_s", 32'(bus.grant), 32'h1);

        // btnD arrives while E holds the grant: no preemption, S follows the GAP
        btns(0, 1, 0, 0);
        do_reset();
        step();
        chk("np_first", 32'(bus.grant), 32'h2);
        bus.btnD = 1'b1;
        step();
        step();
        chk("np_hold", 32'(bus.grant), 32'h2);
        n = 0;
        while (bus.grant != 4'b0000 && n < 20) begin step(); n++; end
        chk("np_gap_busy", 32'(bus.busy), 32'h1);
        chk("np_gap_led",  32'(bus.LED),  32'h00);
        n = 0;
        while (bus.grant == 4'b0000 && n < 20) begin step(); n++; end
        chk("np_next_s", 32'(bus.grant), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seat_arbiter.md
SEAT_ARBITER -- requirements
Module: seat_arbiter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 26: tick fires when prescaler bit [TICK_DIV] is set, giving a period of 2^TICK_DIV+1 clk cycles.
REQ-002 SHALL have parameter HOLD_TICKS, default 4: maximum number of ticks a grant lasts, legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port btnD, input, 1 bit: request from seat S (index 0).
REQ-006 SHALL have port btnR, input, 1 bit: request from seat E (index 1).
REQ-007 SHALL have port btnU, input, 1 bit: request from seat N (index 2).
REQ-008 SHALL have port btnL, input, 1 bit: request from seat W (index 3).
REQ-009 SHALL have port grant, output, 4 bits: one-hot current grantee, bit k = seat k.
REQ-010 SHALL have port busy, output, 1 bit: high in GRANT and GAP.
REQ-011 SHALL have port LED, output, 8 bits: shared display; LED[2k+1:2k]=2'b11 for grantee k, all other bits 0.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT and GAP; all outputs registered.
REQ-013 SHALL, in IDLE, move to GRANT the cycle after any effective request is high, without waiting for a tick; grant/LED valid from that cycle.
REQ-014 SHALL select the grantee round-robin in order S,E,N,W, searching from the seat after the last grantee; last grantee is updated on each grant.
REQ-015 SHALL, in GRANT, increment hold_cnt on each tick and go to GAP on the tick where hold_cnt == HOLD_TICKS-1.
REQ-016 SHALL, in GRANT, go to GAP on the next cycle when the grantee's effective request is low (early release), regardless of tick.
REQ-017 SHALL, in GAP, drive grant=0 and LED=8'h00, and return to IDLE on the next tick.
REQ-018 SHALL ignore requests during GAP; they are arbitrated in IDLE only.
REQ-019 SHALL, for simultaneous requests in IDLE, grant exactly one seat per REQ-014.
REQ-020 SHALL NOT preempt an ongoing grant, even for a higher-priority requester.
REQ-021 SHALL run the prescaler free, independent of FSM state; tick is a one-cycle pulse, after which the counter returns to 0.

Reset
REQ-022 SHALL, on rst low, asynchronously clear state to IDLE, prescaler, hold_cnt, grant=0, busy=0, LED=8'h00, and set last grantee=W so that S has first priority.
REQ-023 SHALL, on reset mid-grant, drop the grant immediately, and SHALL NOT retain any pending request across reset.

Configuration
REQ-024 SHALL support macro ARB_EDGE_REQ_EN: when defined, each seat has a pending bit set on a rising request edge (prev register resets to 0, so a button held at reset release counts as an edge), cleared when granted; the effective request is the pending bit, and early release (REQ-016) is disabled.
REQ-025 SHALL, when ARB_EDGE_REQ_EN is undefined, use the raw level inputs as the effective request.

Structure
REQ-026 SHALL place the state enum, seat index constants (SEAT_S..SEAT_W) and the LED pattern function in package seat_arb_pkg.
REQ-027 SHALL implement the prescaler as sub-module tick_gen, with parameter TICK_DIV and output tick.

Verification (TICK_DIV=2, tick period 5 cycles, HOLD_TICKS=2)
REQ-028 SHALL verify: btnU held from reset -> grant=4'b0100 and LED=8'h30 one cycle after the request is seen; GAP after the 2nd tick; then regrant N.
REQ-029 SHALL verify: btnD, btnR, btnU and btnL all held -> grants in order S,E,N,W,S, each separated by a GAP with LED=8'h00.
REQ-030 SHALL verify: btnR pulsed for 3 cycles in level mode -> grant=4'b0010 for at most 3 cycles, then GAP, then IDLE on the next tick.
REQ-031 SHALL verify: with ARB_EDGE_REQ_EN, a one-cycle btnL pulse -> W granted for exactly 2 ticks, and pending[3] is cleared.
REQ-032 SHALL verify: rst asserted mid-GRANT -> grant=0, LED=0 and busy=0 in the same cycle; S wins first after release.
REQ-033 SHALL verify: btnD requested while E is in GRANT -> E is not preempted; S is granted after the GAP.
